// File: rtl/nor_stim_checker.sv
// nor_stim_checker
// Drives the four 2-bit input vectors (00, 10, 01, 11) into an external
// 2-input NOR gate, holds each one for HOLD_CYCLES clocks, and samples the
// gate output once per vector on the last hold cycle. It accumulates a
// mismatch count and a per-vector failure mask, then reports pass/fail.
//
// Handshake: start is a level request sampled on rising edges of clk.
// It is accepted only in IDLE or DONE while rst is low. There is no
// separate ready signal. busy rising on the next edge is the
// acknowledgement. While busy=1, start is ignored. done=1 marks the
// results as valid until the next accepted start or reset.
//
// HOLD_CYCLES legal range is 2..255; the hold counter is 8 bits wide.

module nor_stim_checker #(
    parameter int HOLD_CYCLES = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       op,
    output logic       input1,
    output logic       input2,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_mask,
    output logic [1:0] vec_idx,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Value of the hold counter on the cycle in which op is sampled.
    localparam logic [7:0] LAST_HOLD = 8'(HOLD_CYCLES - 1);
    localparam logic [2:0] ERR_MAX   = 3'd4;

    state_t     r_state;
    logic [1:0] r_vec_idx;
    logic [7:0] r_hold_cnt;
    logic [2:0] r_err_count;
    logic [3:0] r_fail_mask;
    logic       r_input1;
    logic       r_input2;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;

    logic       w_sample;
    logic       w_expected;
    logic       w_mismatch;
    logic       w_last_vec;
    logic [1:0] w_next_vec;
    logic [2:0] w_err_next;
    logic [3:0] w_mask_next;

    // The last hold cycle of the current vector is the only sampling point.
    assign w_sample   = (r_state == ST_RUN) && (r_hold_cnt == LAST_HOLD);

    // The reference is derived from the registered operands actually on the pins.
    assign w_expected = ~(r_input1 | r_input2);

    // Case equality makes an unknown op count as a mismatch in simulation.
    // In hardware it reduces to an ordinary compare.
    assign w_mismatch = w_sample && !(op === w_expected);

    assign w_last_vec = (r_vec_idx == 2'd3);

    // Operand bit order follows the vector index: input1 = idx[0], input2 = idx[1].
    assign w_next_vec = r_vec_idx + 2'd1;

    // Result accumulation for the current sample. The count saturates at four.
    always_comb begin
        w_err_next  = r_err_count;
        w_mask_next = r_fail_mask;
        if (w_mismatch) begin
            if (r_err_count != ERR_MAX) begin
                w_err_next = r_err_count + 3'd1;
            end
            w_mask_next[r_vec_idx] = 1'b1;
        end
    end

    // Sweep controller: state, vector sequencing, hold timing and registered results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_vec_idx   <= 2'd0;
            r_hold_cnt  <= 8'd0;
            r_err_count <= 3'd0;
            r_fail_mask <= 4'd0;
            r_input1    <= 1'b0;
            r_input2    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
        end else begin
            case (r_state)
                // IDLE and DONE accept a start identically.
                // A new sweep always begins with cleared results.
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state     <= ST_RUN;
                        r_vec_idx   <= 2'd0;
                        r_hold_cnt  <= 8'd0;
                        r_err_count <= 3'd0;
                        r_fail_mask <= 4'd0;
                        r_input1    <= 1'b0;
                        r_input2    <= 1'b0;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                    end
                end

                ST_RUN: begin
                    r_err_count <= w_err_next;
                    r_fail_mask <= w_mask_next;
                    if (w_sample) begin
                        r_hold_cnt <= 8'd0;
                        if (w_last_vec) begin
                            // The last vector has been sampled, so close the
                            // sweep. pass includes the result of this final sample.
                            r_state  <= ST_DONE;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_pass   <= (w_err_next == 3'd0);
                            r_input1 <= 1'b0;
                            r_input2 <= 1'b0;
                        end else begin
                            r_vec_idx <= w_next_vec;
                            r_input1  <= w_next_vec[0];
                            r_input2  <= w_next_vec[1];
                        end
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 8'd1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign input1    = r_input1;
    assign input2    = r_input2;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err_count;
    assign fail_mask = r_fail_mask;
    assign vec_idx   = r_vec_idx;
    assign dbg_state = r_state;

endmodule
